// File: rtl/core_mem_port_if.sv
// Bundle between a core's memory requester, its core pipeline and its slice of the shared DataMEM ports.
// The master modport is the requester; the slave modport is the core/memory side.
interface core_mem_port_if #(
  parameter int TAM = 16
);
  logic           cpu_req_valid;
  logic           cpu_req_ready;
  logic           cpu_req_we;
  logic [TAM-1:0] cpu_req_addr;
  logic [TAM-1:0] cpu_req_wdata;
  logic           cpu_rsp_valid;
  logic [TAM-1:0] cpu_rsp_rdata;
  logic           cpu_rsp_err;
  logic           busy;
  logic [TAM-1:0] mem_addr;
  logic [TAM-1:0] mem_wdata;
  logic [1:0]     mem_ctrl;
  logic [TAM-1:0] mem_rdata;

  modport master (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, mem_rdata,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err, busy,
           mem_addr, mem_wdata, mem_ctrl
  );

  modport slave (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, mem_rdata,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err, busy,
           mem_addr, mem_wdata, mem_ctrl
  );
endinterface

// File: rtl/core_mem_port.sv
// Per-core DataMEM requester: buffers load/store requests in a small FIFO and runs them one at a time
// through a fixed-latency memory, returning a one-cycle response per request in order.
module core_mem_port #(
  parameter int TAM        = 16,
  parameter int Lmem       = 255,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  core_mem_port_if.master  io_bus
);

  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);
  localparam logic [TAM-1:0] ADDR_MAX = TAM'(Lmem);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  logic           r_fifo_we    [FIFO_DEPTH];
  logic [TAM-1:0] r_fifo_addr  [FIFO_DEPTH];
  logic [TAM-1:0] r_fifo_wdata [FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_count;

  state_t         r_state;
  logic           r_op_we;
  logic           r_op_err;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_mem_ctrl;
  logic [TAM-1:0] r_mem_addr;
  logic [TAM-1:0] r_mem_wdata;
  logic           r_rsp_valid;
  logic [TAM-1:0] r_rsp_rdata;
  logic           r_rsp_err;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_take;
  logic           w_bypass;
  logic           w_store;
  logic           w_pop;
  logic           w_head_we;
  logic [TAM-1:0] w_head_addr;
  logic [TAM-1:0] w_head_wdata;
  logic           w_head_err;

  assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = io_bus.cpu_req_valid && !w_full;

  // An arriving request reaches ISSUE at the very next edge when the FIFO is empty.
  assign w_take   = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && (!w_empty || w_push);
  assign w_bypass = w_take && w_empty;
  assign w_store  = w_push && !w_bypass;
  assign w_pop    = w_take && !w_empty;

  assign w_head_we    = w_empty ? io_bus.cpu_req_we    : r_fifo_we[r_rd_ptr];
  assign w_head_addr  = w_empty ? io_bus.cpu_req_addr  : r_fifo_addr[r_rd_ptr];
  assign w_head_wdata = w_empty ? io_bus.cpu_req_wdata : r_fifo_wdata[r_rd_ptr];
  assign w_head_err   = (w_head_addr > ADDR_MAX);

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_fifo_we[r_wr_ptr]    <= io_bus.cpu_req_we;
      r_fifo_addr[r_wr_ptr]  <= io_bus.cpu_req_addr;
      r_fifo_wdata[r_wr_ptr] <= io_bus.cpu_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Bus outputs are loaded on entry to ISSUE so they are live for exactly that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_op_we     <= 1'b0;
      r_op_err    <= 1'b0;
      r_cnt       <= '0;
      r_mem_ctrl  <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_take) begin
            r_state  <= ST_ISSUE;
            r_op_we  <= w_head_we;
            r_op_err <= w_head_err;
            if (!w_head_err) begin
              r_mem_ctrl  <= w_head_we ? 2'b10 : 2'b01;
              r_mem_addr  <= w_head_addr;
              r_mem_wdata <= w_head_wdata;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_mem_ctrl <= 2'b00;
          if (r_op_err) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_state <= ST_WAIT;
            r_cnt   <= r_op_we ? CW'(WR_LAT) : CW'(RD_LAT);
          end
        end
        ST_WAIT: begin
          if (r_cnt == CW'(1)) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_op_we ? '0 : io_bus.mem_rdata;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.cpu_req_ready = !w_full;
  assign io_bus.cpu_rsp_valid = r_rsp_valid;
  assign io_bus.cpu_rsp_rdata = r_rsp_rdata;
  assign io_bus.cpu_rsp_err   = r_rsp_err;
  assign io_bus.busy          = (r_state != ST_IDLE) || !w_empty;
  assign io_bus.mem_ctrl      = r_mem_ctrl;
  assign io_bus.mem_addr      = r_mem_addr;
  assign io_bus.mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_core_mem_port.sv
// Bench for core_mem_port: three requesters with different read/write latencies, each on its own
// exact-latency memory model, checked by a response scoreboard fed from a reference memory.
module tb_core_mem_port;
  localparam int TAM   = 16;
  localparam int LMEM  = 255;
  localparam int LANES = 3;

  typedef struct packed {
    logic [TAM-1:0] rdata;
    logic           err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  logic [LANES-1:0]          reqValid;
  logic [LANES-1:0]          reqWe;
  logic [LANES-1:0][TAM-1:0] reqAddr;
  logic [LANES-1:0][TAM-1:0] reqWdata;
  logic [LANES-1:0]          reqReady;
  logic [LANES-1:0]          rspValid;
  logic [LANES-1:0][TAM-1:0] rspRdata;
  logic [LANES-1:0]          rspErr;
  logic [LANES-1:0]          busyW;
  logic [1:0]                ctrl0;
  logic [TAM-1:0]            memAddr0;

  rsp_t           expQ   [LANES][$];
  logic [TAM-1:0] refMem [LANES][256];
  int             rspCycQ0[$];
  int             ctrlCount0 = 0;
  int             ctrlCyc0 = 0;
  logic [1:0]     ctrlVal0 = 2'b00;
  logic [TAM-1:0] ctrlAddr0 = '0;
  int             lastAcceptCyc = 0;
  bit             sawNotReady = 1'b0;

  function automatic logic [TAM-1:0] memPattern(input int lane, input int a);
    return TAM'(a * 1031 + lane * 4099) ^ 16'hA5C3;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane 0 is the directed-test lane; lanes 1 and 2 cover the other read latencies.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int LRD = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    localparam int LWR = (g == 2) ? 2 : 1;

    core_mem_port_if #(.TAM(TAM)) bus ();

    logic [TAM-1:0] memArr [256];
    logic           rdPending;
    int             rdAge;
    logic [TAM-1:0] rdAddr;

    core_mem_port #(
      .TAM(TAM), .Lmem(LMEM), .RD_LAT(LRD), .WR_LAT(LWR), .FIFO_DEPTH(2)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
    );

    assign bus.cpu_req_valid = reqValid[g];
    assign bus.cpu_req_we    = reqWe[g];
    assign bus.cpu_req_addr  = reqAddr[g];
    assign bus.cpu_req_wdata = reqWdata[g];
    assign reqReady[g]       = bus.cpu_req_ready;
    assign rspValid[g]       = bus.cpu_rsp_valid;
    assign rspRdata[g]       = bus.cpu_rsp_rdata;
    assign rspErr[g]         = bus.cpu_rsp_err;
    assign busyW[g]          = bus.busy;

    // Read data is only correct in the single cycle whose closing edge is the sample edge.
    assign bus.mem_rdata = (rdPending && rdAge == LRD - 1) ? memArr[rdAddr[7:0]] : ~memArr[rdAddr[7:0]];

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdPending <= 1'b0;
        rdAge     <= 0;
        rdAddr    <= '0;
        for (int i = 0; i < 256; i++) memArr[i] <= memPattern(g, i);
      end else begin
        if (bus.mem_ctrl == 2'b01) begin
          rdPending <= 1'b1;
          rdAge     <= 0;
          rdAddr    <= bus.mem_addr;
        end else if (rdPending) begin
          if (rdAge == LRD - 1) rdPending <= 1'b0;
          else                  rdAge <= rdAge + 1;
        end
        if (bus.mem_ctrl == 2'b10) memArr[bus.mem_addr[7:0]] <= bus.mem_wdata;
      end
    end
  end

  assign ctrl0    = g_lane[0].bus.mem_ctrl;
  assign memAddr0 = g_lane[0].bus.mem_addr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  // Scoreboard monitor: every response pulse pops the oldest expectation of its lane.
  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      if (ctrl0 != 2'b00) begin
        ctrlCount0 = ctrlCount0 + 1;
        ctrlCyc0   = cyc;
        ctrlVal0   = ctrl0;
        ctrlAddr0  = memAddr0;
      end
      for (int l = 0; l < LANES; l++) begin
        if (rspValid[l]) begin
          if (l == 0) rspCycQ0.push_back(cyc);
          if (expQ[l].size() == 0) begin
            reportFail($sformatf("rsp_unexpected_lane%0d", l),
                       $sformatf("got rdata 0x%0h err %0b, required no response", rspRdata[l], rspErr[l]));
          end else begin
            e = expQ[l].pop_front();
            checkOutput($sformatf("rsp_rdata_lane%0d", l), 32'(rspRdata[l]), 32'(e.rdata));
            checkOutput($sformatf("rsp_err_lane%0d", l), 32'(rspErr[l]), 32'(e.err));
          end
        end
      end
    end
  end

  // Called just after a falling edge; returns at the falling edge after the accepting edge.
  task automatic applyStimulus(input int lane, input logic we, input logic [TAM-1:0] addr,
                               input logic [TAM-1:0] wdata);
    int   guard;
    rsp_t e;
    guard = 0;
    reqValid[lane] = 1'b1;
    reqWe[lane]    = we;
    reqAddr[lane]  = addr;
    reqWdata[lane] = wdata;
    while (!reqReady[lane] && guard < 100) begin
      sawNotReady = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (!reqReady[lane]) begin
      reportFail("req_accept_timeout", $sformatf("lane %0d ready stayed 0, required 1", lane));
      reqValid[lane] = 1'b0;
      return;
    end
    lastAcceptCyc = cyc;
    e.err = (addr > TAM'(LMEM));
    if (e.err) begin
      e.rdata = '0;
    end else if (we) begin
      refMem[lane][addr[7:0]] = wdata;
      e.rdata = '0;
    end else begin
      e.rdata = refMem[lane][addr[7:0]];
    end
    expQ[lane].push_back(e);
    @(negedge clk);
    reqValid[lane] = 1'b0;
  endtask

  task automatic waitIdle(input int lane, input int budget);
    int n;
    n = 0;
    while ((expQ[lane].size() != 0 || busyW[lane]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (expQ[lane].size() != 0 || busyW[lane])
      reportFail("idle_timeout", $sformatf("lane %0d still has %0d pending, required 0", lane, expQ[lane].size()));
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      expQ[l].delete();
      for (int a = 0; a < 256; a++) refMem[l][a] = memPattern(l, a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int rspAt(input int idx, input int base);
    if (rspCycQ0.size() > idx) return rspCycQ0[idx] - base;
    return -1;
  endfunction

  initial begin
    int             acc;
    int             ctrlBase;
    int             cls;
    logic [TAM-1:0] a;

    reqValid = '0;
    reqWe    = '0;
    reqAddr  = '0;
    reqWdata = '0;
    doReset();

    checkOutput("reset_ready", 32'(reqReady[0]), 1);
    checkOutput("reset_busy", 32'(busyW[0]), 0);
    checkOutput("reset_mem_ctrl", 32'(ctrl0), 0);
    checkOutput("reset_mem_addr", 32'(memAddr0), 0);
    checkOutput("reset_rsp_valid", 32'(rspValid[0]), 0);
    checkOutput("reset_rsp_rdata", 32'(rspRdata[0]), 0);

    $display("[TB] load returning 0xBEEF after RD_LAT=2");
    applyStimulus(0, 1'b1, 16'h0010, 16'hBEEF);
    waitIdle(0, 50);
    rspCycQ0.delete();
    ctrlBase = ctrlCount0;
    applyStimulus(0, 1'b0, 16'h0010, '0);
    acc = lastAcceptCyc;
    waitIdle(0, 50);
    checkOutput("t1_rsp_latency", rspAt(0, acc), 4);
    checkOutput("t1_ctrl_cycles", ctrlCount0 - ctrlBase, 1);
    checkOutput("t1_ctrl_issue_cycle", ctrlCyc0 - acc, 1);
    checkOutput("t1_ctrl_value", 32'(ctrlVal0), 1);
    checkOutput("t1_ctrl_addr", 32'(ctrlAddr0), 32'h10);

    $display("[TB] store then load of the same word");
    rspCycQ0.delete();
    applyStimulus(0, 1'b1, 16'h0020, 16'h1234);
    acc = lastAcceptCyc;
    applyStimulus(0, 1'b0, 16'h0020, '0);
    waitIdle(0, 50);
    checkOutput("t2_write_latency", rspAt(0, acc), 3);
    checkOutput("t2_read_latency", rspAt(1, acc), 7);

    $display("[TB] back-to-back requests filling the FIFO");
    rspCycQ0.delete();
    sawNotReady = 1'b0;
    applyStimulus(0, 1'b0, 16'h0010, '0);
    acc = lastAcceptCyc;
    applyStimulus(0, 1'b0, 16'h0020, '0);
    applyStimulus(0, 1'b1, 16'h0030, 16'h5555);
    applyStimulus(0, 1'b0, 16'h00FF, '0);
    waitIdle(0, 100);
    checkOutput("t3_ready_dropped", 32'(sawNotReady), 1);
    checkOutput("t3_first_latency", rspAt(0, acc), 4);
    checkOutput("t3_gap_1_2", rspAt(1, 0) - rspAt(0, 0), 4);
    checkOutput("t3_gap_2_3", rspAt(2, 0) - rspAt(1, 0), 3);
    checkOutput("t3_gap_3_4", rspAt(3, 0) - rspAt(2, 0), 4);

    $display("[TB] out-of-range addresses");
    rspCycQ0.delete();
    ctrlBase = ctrlCount0;
    applyStimulus(0, 1'b0, 16'h0100, '0);
    acc = lastAcceptCyc;
    waitIdle(0, 50);
    applyStimulus(0, 1'b1, 16'hFFFF, 16'h7777);
    waitIdle(0, 50);
    checkOutput("t4_err_latency", rspAt(0, acc), 2);
    checkOutput("t4_ctrl_cycles", ctrlCount0 - ctrlBase, 0);

    $display("[TB] reset during the wait of a load");
    applyStimulus(0, 1'b0, 16'h0020, '0);
    @(negedge clk);
    checkOutput("t5_busy_in_wait", 32'(busyW[0]), 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("t5_ctrl_async", 32'(ctrl0), 0);
    checkOutput("t5_busy_async", 32'(busyW[0]), 0);
    checkOutput("t5_ready_async", 32'(reqReady[0]), 1);
    doReset();
    rspCycQ0.delete();
    repeat (10) @(negedge clk);
    checkOutput("t5_no_rsp_after_reset", rspCycQ0.size(), 0);
    applyStimulus(0, 1'b0, 16'h0010, '0);
    acc = lastAcceptCyc;
    waitIdle(0, 50);
    checkOutput("t5_load_after_reset", rspAt(0, acc), 4);

    $display("[TB] randomized load/store mix on every lane");
    for (int l = 0; l < LANES; l++) begin
      for (int n = 0; n < 60; n++) begin
        cls = int'($urandom_range(0, 9));
        case (cls)
          6:       a = 16'h00FF;
          7:       a = 16'h0100;
          8:       a = TAM'($urandom_range(257, 65535));
          9:       a = TAM'($urandom_range(0, 255));
          default: a = TAM'($urandom_range(0, 15));
        endcase
        applyStimulus(l, 1'($urandom_range(0, 1)), a, TAM'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      waitIdle(l, 2000);
    end

    for (int l = 0; l < LANES; l++)
      checkOutput($sformatf("queue_drained_lane%0d", l), expQ[l].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
